instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the 8-bit accumulator processor.
- Drives the program ROM address and data RAM address and write enable with explicit wait states for their synchronous read latency.
- Issues one-cycle control strobes to the register file, ULA and output port: register write, ALU start, RAM write, print.
- Replaces free-running PC increment with a single FSM, so every instruction completes before the next fetch.

Parameters:
- ROM_LAT, 1, program ROM read latency in clocks (1..3).
- RAM_LAT, 1, data RAM read latency in clocks (1..3).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- run  input  1  level; 1 = keep fetching instructions
- step  input  1  single-step pulse (used only with SINGLE_STEP_EN)
- rom_addr  output  8  program ROM address
- rom_data  input  16  program ROM read data
- ram_addr  output  8  data RAM address
- ram_we  output  1  data RAM write enable
- pc  output  8  program counter
- ir  output  16  latched instruction
- wb_en  output  1  register write strobe
- wb_dst  output  3  destination: 0 ACC, 1 REGA, 2 REGB, 3 REGC, 4 MADDR
- wb_src  output  2  0 IMM, 1 ZERO, 2 ALU, 3 RAM
- alu_en  output  1  ALU operand-latch strobe
- alu_op  output  4  ULA opcode
- b_sel  output  3  ALU B operand: 0 immediate, 1 REGA, 2 REGB, 3 REGC
- st_sel  output  3  STORE data source; same encoding as wb_dst; value 5 = ACC
- print_en  output  1  PRINT strobe
- illegal  output  1  one-cycle pulse on opcode 13..15
- busy  output  1  1 in any state except IDLE
- instr_done  output  1  one-cycle pulse in the last cycle of each instruction

Behaviour:
- Instruction format: [15:12] opcode, [11:8] select, [7:0] immediate or address.
- Opcodes: NOP 0, ADD 1, SUB 2, AND 3, OR 4, NOT 5, XOR 6, CLEAR 7, MOVE 8, LOAD 9, STORE 10, PRINT 11, JMP 12.
- Select values >4 map to ACC for wb_dst and for st_sel; for b_sel they map to 0 (immediate).
- Reset value of every output is 0 (rom_addr, ram_addr, pc, ir, all strobes); state is IDLE.
- Reset mid-instruction aborts immediately with no strobe. ram_we is never left asserted.
- States:
  - IDLE: leave when run=1; next state FETCH.
  - FETCH: 1 cycle; rom_addr<=pc.
  - FWAIT: ROM_LAT cycles, timed by a down-counter.
  - DECODE: 1 cycle; ir<=rom_data.
  - EXEC: 1 cycle; behaviour by opcode below.
  - MEM: RAM_LAT cycles; ram_addr held.
  - WB: 1 cycle.
- EXEC behaviour by opcode:
  - MOVE: wb_en, wb_src=IMM, wb_dst from select.
  - CLEAR: wb_en, wb_src=ZERO.
  - ALU ops (1..6): alu_en, alu_op=opcode, b_sel from select; next state WB.
  - STORE: ram_we=1 for exactly 1 cycle, ram_addr=ir[7:0], st_sel driven.
  - LOAD: ram_addr=ir[7:0], ram_we=0; next state MEM.
  - PRINT: print_en.
  - JMP: pc<=ir[7:0].
  - NOP and illegal opcodes: no strobe except illegal.
- PC update: all opcodes except JMP do pc<=pc+1 in EXEC. pc wraps 255->0.
- WB behaviour:
  - ALU ops: wb_en, wb_dst=ACC, wb_src=ALU.
  - LOAD: wb_en, wb_src=RAM, wb_dst from select.
- instr_done asserts in EXEC for single-phase ops and in WB for ALU ops and LOAD.
- After the instr_done cycle: next state FETCH if run=1, else IDLE.
- run dropping mid-instruction: the current instruction completes, then IDLE.
- Latency with ROM_LAT=RAM_LAT=1: FETCH to instr_done takes 4 cycles for single-phase ops, 5 for ALU ops, 6 for LOAD.
- Strobes are decoded from state and ir, with no combinational path from rom_data.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined: when run=0, a one-cycle step pulse in IDLE executes exactly one instruction and returns to IDLE. step in any other state is ignored; step with run=1 has no extra effect.
- Not defined: step is ignored and only run starts execution.

Test Plan:
- Reset mid-instruction: rst asserted during FWAIT -> next cycle all outputs 0, state IDLE, pc=0.
- MOVE then ADD: ROM[0]=0x8105 (MOVE REGA,5), ROM[1]=0x1100 (ADD REGA), run=1 -> wb_en with wb_dst=1, wb_src=IMM at cycle 4; alu_en with b_sel=1 at cycle 8; wb_en with wb_dst=0, wb_src=ALU at cycle 9; pc=2.
- STORE then LOAD: ROM[0]=0xA120, ROM[1]=0x9220 -> ram_we high exactly 1 cycle with ram_addr=0x20, st_sel=1; LOAD holds ram_addr=0x20 through MEM, then wb_en with wb_dst=2, wb_src=RAM; instr_done spacing 4 then 6 cycles.
- JMP loop and wrap: ROM[0]=0xC0FF, ROM[255]=0x0000 -> pc goes 0->255->0; rom_addr=0xFF on the second FETCH.
- Illegal opcode and run drop: ROM[0]=0xE000 -> illegal pulses 1 cycle, no other strobe, pc=1; run dropped in DECODE of the next instruction -> that instruction completes, then busy=0.
- SINGLE_STEP_EN build, run=0: three step pulses -> exactly three instr_done pulses, pc=3; with the macro undefined the same stimulus gives pc=0.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Bus bundle for the instruction sequencer: run/step control, ROM/RAM ports and decoded strobes.
// The slave modport is the sequencer side. The master modport is the datapath/memory side.
interface instr_sequencer_if;
    logic        run;
    logic        step;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        wb_en;
    logic [2:0]  wb_dst;
    logic [1:0]  wb_src;
    logic        alu_en;
    logic [3:0]  alu_op;
    logic [2:0]  b_sel;
    logic [2:0]  st_sel;
    logic        print_en;
    logic        illegal;
    logic        busy;
    logic        instr_done;

    modport slave (
        input  run, step, rom_data,
        output rom_addr, ram_addr, ram_we, pc, ir, wb_en, wb_dst, wb_src,
               alu_en, alu_op, b_sel, st_sel, print_en, illegal, busy, instr_done
    );

    modport master (
        output run, step, rom_data,
        input  rom_addr, ram_addr, ram_we, pc, ir, wb_en, wb_dst, wb_src,
               alu_en, alu_op, b_sel, st_sel, print_en, illegal, busy, instr_done
    );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute FSM for the 8-bit accumulator CPU, with ROM/RAM wait states and one-cycle strobes.
// Optional SINGLE_STEP_EN: while run=0, a step pulse in IDLE runs exactly one instruction.
module instr_sequencer #(
    parameter int ROM_LAT = 1,
    parameter int RAM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    instr_sequencer_if.slave   seq_io
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_CLEAR = 4'd7;
    localparam logic [3:0] OP_MOVE  = 4'd8;
    localparam logic [3:0] OP_LOAD  = 4'd9;
    localparam logic [3:0] OP_STORE = 4'd10;
    localparam logic [3:0] OP_PRINT = 4'd11;
    localparam logic [3:0] OP_JMP   = 4'd12;
    localparam logic [3:0] OP_ILL   = 4'd13;

    localparam logic [1:0] SRC_IMM  = 2'd0;
    localparam logic [1:0] SRC_ZERO = 2'd1;
    localparam logic [1:0] SRC_ALU  = 2'd2;
    localparam logic [1:0] SRC_RAM  = 2'd3;

    localparam logic [1:0] ROM_WAIT = 2'(ROM_LAT - 1);
    localparam logic [1:0] RAM_WAIT = 2'(RAM_LAT - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic [15:0] ir_q, ir_d;

    logic [3:0]  op, sel;
    logic [7:0]  imm;
    logic        is_alu, start;
    logic [2:0]  dst_map, st_map, bsel_map;
    state_t      after_done;

    logic [7:0]  ram_addr;
    logic        ram_we, wb_en, alu_en, print_en, illegal, instr_done;
    logic [2:0]  wb_dst, b_sel, st_sel;
    logic [1:0]  wb_src;
    logic [3:0]  alu_op;

    assign op     = ir_q[15:12];
    assign sel    = ir_q[11:8];
    assign imm    = ir_q[7:0];
    assign is_alu = (op >= OP_ADD) && (op <= OP_XOR);

    // Out-of-range selects fall back to ACC (dst/store) or to the immediate (ALU B).
    assign dst_map  = (sel <= 4'd4) ? sel[2:0] : 3'd0;
    assign st_map   = (sel <= 4'd4) ? sel[2:0] : 3'd5;
    assign bsel_map = (sel <= 4'd4) ? sel[2:0] : 3'd0;

    assign after_done = seq_io.run ? S_FETCH : S_IDLE;

`ifdef SINGLE_STEP_EN
    assign start = seq_io.run | seq_io.step;
`else
    logic unused_step;
    assign unused_step = seq_io.step;
    assign start       = seq_io.run;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            pc_q       <= 8'd0;
            rom_addr_q <= 8'd0;
            ir_q       <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            rom_addr_q <= rom_addr_d;
            ir_q       <= ir_d;
        end
    end

    // Strobes depend only on state_q and ir_q, so rom_data never reaches an output combinationally.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        rom_addr_d = rom_addr_q;
        ir_d       = ir_q;
        ram_addr   = 8'd0;
        ram_we     = 1'b0;
        wb_en      = 1'b0;
        wb_dst     = 3'd0;
        wb_src     = SRC_IMM;
        alu_en     = 1'b0;
        alu_op     = 4'd0;
        b_sel      = 3'd0;
        st_sel     = 3'd0;
        print_en   = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                rom_addr_d = pc_q;
                cnt_d      = ROM_WAIT;
                state_d    = S_FWAIT;
            end
            S_FWAIT: begin
                if (cnt_q == 2'd0) state_d = S_DECODE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            S_DECODE: begin
                ir_d    = seq_io.rom_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                pc_d = (op == OP_JMP) ? imm : pc_q + 8'd1;
                if (is_alu) begin
                    alu_en  = 1'b1;
                    alu_op  = op;
                    b_sel   = bsel_map;
                    state_d = S_WB;
                end else if (op == OP_LOAD) begin
                    ram_addr = imm;
                    cnt_d    = RAM_WAIT;
                    state_d  = S_MEM;
                end else begin
                    case (op)
                        OP_MOVE: begin
                            wb_en  = 1'b1;
                            wb_src = SRC_IMM;
                            wb_dst = dst_map;
                        end
                        OP_CLEAR: begin
                            wb_en  = 1'b1;
                            wb_src = SRC_ZERO;
                            wb_dst = dst_map;
                        end
                        OP_STORE: begin
                            ram_we   = 1'b1;
                            ram_addr = imm;
                            st_sel   = st_map;
                        end
                        OP_PRINT: print_en = 1'b1;
                        default:  illegal  = (op >= OP_ILL);
                    endcase
                    instr_done = 1'b1;
                    state_d    = after_done;
                end
            end
            S_MEM: begin
                ram_addr = imm;
                if (cnt_q == 2'd0) state_d = S_WB;
                else               cnt_d   = cnt_q - 2'd1;
            end
            S_WB: begin
                wb_en = 1'b1;
                if (op == OP_LOAD) begin
                    wb_src = SRC_RAM;
                    wb_dst = dst_map;
                end else begin
                    wb_src = SRC_ALU;
                    wb_dst = 3'd0;
                end
                instr_done = 1'b1;
                state_d    = after_done;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign seq_io.rom_addr   = rom_addr_q;
    assign seq_io.pc         = pc_q;
    assign seq_io.ir         = ir_q;
    assign seq_io.ram_addr   = ram_addr;
    assign seq_io.ram_we     = ram_we;
    assign seq_io.wb_en      = wb_en;
    assign seq_io.wb_dst     = wb_dst;
    assign seq_io.wb_src     = wb_src;
    assign seq_io.alu_en     = alu_en;
    assign seq_io.alu_op     = alu_op;
    assign seq_io.b_sel      = b_sel;
    assign seq_io.st_sel     = st_sel;
    assign seq_io.print_en   = print_en;
    assign seq_io.illegal    = illegal;
    assign seq_io.busy       = (state_q != S_IDLE);
    assign seq_io.instr_done = instr_done;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with ROM_LAT=RAM_LAT=1. Cycle c counts clock edges after run/step is raised in IDLE.
// Expected values are hand-derived: FETCH=1, FWAIT=2, DECODE=3, EXEC=4, then MEM/WB or the next FETCH.
module tb_instr_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_sequencer_if sif();
    instr_sequencer #(.ROM_LAT(1), .RAM_LAT(1)) dut (.clk(clk), .rst(rst), .seq_io(sif.slave));

    logic [15:0] rom [0:255];
    always @(posedge clk) sif.rom_data <= rom[sif.rom_addr];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        sif.run  = 1'b0;
        sif.step = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    function automatic logic [31:0] strobes();
        return 32'({sif.ram_we, sif.wb_en, sif.alu_en, sif.print_en, sif.illegal, sif.instr_done});
    endfunction

    initial begin
        int we_cnt, ill_cnt, other_cnt, done_cnt, prn_cnt;
        int done_at [0:7];

        // Reset values
        do_reset;
        chk("rst_pc", 32'(sif.pc), 0);
        chk("rst_ir", 32'(sif.ir), 0);
        chk("rst_rom_addr", 32'(sif.rom_addr), 0);
        chk("rst_ram_addr", 32'(sif.ram_addr), 0);
        chk("rst_busy", 32'(sif.busy), 0);
        chk("rst_strobes", strobes(), 0);

        // MOVE REGA,5 then ADD REGA
        rom[0] = 16'h8105;
        rom[1] = 16'h1100;
        sif.run = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick;
            case (c)
                1: chk("mv_busy", 32'(sif.busy), 1);
                4: begin
                    chk("mv_wb", 32'({sif.wb_en, sif.wb_dst, sif.wb_src}), 'b1_001_00);
                    chk("mv_done", 32'(sif.instr_done), 1);
                end
                5: chk("mv_pc", 32'(sif.pc), 1);
                8: begin
                    chk("add_alu", 32'({sif.alu_en, sif.alu_op, sif.b_sel}), 'b1_0001_001);
                    chk("add_nowb", 32'(sif.wb_en), 0);
                end
                9: begin
                    chk("add_wb", 32'({sif.wb_en, sif.wb_dst, sif.wb_src}), 'b1_000_10);
                    chk("add_done", 32'(sif.instr_done), 1);
                    chk("add_pc", 32'(sif.pc), 2);
                end
                default: ;
            endcase
        end

        // STORE REGA,0x20 / LOAD REGB,0x20 / PRINT, run dropped during PRINT
        do_reset;
        rom[0] = 16'hA120;
        rom[1] = 16'h9220;
        rom[2] = 16'hB000;
        we_cnt = 0;
        done_cnt = 0;
        sif.run = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick;
            we_cnt += int'(sif.ram_we);
            if (sif.instr_done && done_cnt < 8) begin
                done_at[done_cnt] = c;
                done_cnt++;
            end
            case (c)
                4:  chk("st_we", 32'({sif.ram_we, sif.ram_addr, sif.st_sel}), 'b1_00100000_001);
                8:  chk("ld_exec", 32'({sif.ram_we, sif.ram_addr}), 'h020);
                9:  chk("ld_mem", 32'({sif.wb_en, sif.ram_addr}), 'h020);
                10: chk("ld_wb", 32'({sif.wb_en, sif.wb_dst, sif.wb_src}), 'b1_010_11);
                12: sif.run = 1'b0;
                14: chk("prn_en", 32'(sif.print_en), 1);
                15: chk("prn_idle", 32'(sif.busy), 0);
                default: ;
            endcase
        end
        chk("st_we_cnt", 32'(we_cnt), 1);
        chk("stld_done_cnt", 32'(done_cnt), 3);
        if (done_cnt >= 2) begin
            chk("done_gap0", 32'(done_at[0]), 4);
            chk("done_gap1", 32'(done_at[1] - done_at[0]), 6);
        end

        // JMP 0xFF, NOP at 0xFF, pc wraps to 0
        do_reset;
        rom[0] = 16'hC0FF;
        sif.run = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick;
            case (c)
                4:  chk("jmp_pc0", 32'(sif.pc), 0);
                5:  chk("jmp_pc", 32'(sif.pc), 'hFF);
                6:  chk("jmp_rom_addr", 32'(sif.rom_addr), 'hFF);
                9:  chk("wrap_pc", 32'(sif.pc), 0);
                10: chk("wrap_rom_addr", 32'(sif.rom_addr), 0);
                default: ;
            endcase
        end

        // Illegal opcode, then MOVE REGC with run dropped in its DECODE
        do_reset;
        rom[0] = 16'hE000;
        rom[1] = 16'h8305;
        ill_cnt = 0;
        other_cnt = 0;
        sif.run = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick;
            ill_cnt += int'(sif.illegal);
            if (c <= 4) other_cnt += int'(sif.wb_en | sif.alu_en | sif.ram_we | sif.print_en);
            case (c)
                4: chk("ill_pulse", 32'({sif.illegal, sif.instr_done}), 'b11);
                5: chk("ill_pc", 32'(sif.pc), 1);
                7: sif.run = 1'b0;
                8: chk("drop_wb", 32'({sif.wb_en, sif.wb_dst, sif.wb_src, sif.instr_done}), 'b1_011_00_1);
                9: begin
                    chk("drop_busy", 32'(sif.busy), 0);
                    chk("drop_pc", 32'(sif.pc), 2);
                end
                12: chk("drop_stay_idle", 32'(sif.busy), 0);
                default: ;
            endcase
        end
        chk("ill_cnt", 32'(ill_cnt), 1);
        chk("ill_other", 32'(other_cnt), 0);

        // Asynchronous reset during FWAIT of the instruction at 0x10
        do_reset;
        rom[0]  = 16'hC010;
        rom[16] = 16'h8105;
        sif.run = 1'b1;
        for (int c = 1; c <= 6; c++) tick;
        chk("pre_rst_rom_addr", 32'(sif.rom_addr), 'h10);
        chk("pre_rst_ir", 32'(sif.ir), 'hC010);
        rst = 1'b1;
        #1;
        chk("mid_rst_pc", 32'(sif.pc), 0);
        chk("mid_rst_rom_addr", 32'(sif.rom_addr), 0);
        chk("mid_rst_ir", 32'(sif.ir), 0);
        chk("mid_rst_busy", 32'(sif.busy), 0);
        chk("mid_rst_strobes", strobes(), 0);

        // Three step pulses with run=0: PRINT, CLEAR REGC, NOT
        do_reset;
        rom[0] = 16'hB000;
        rom[1] = 16'h7300;
        rom[2] = 16'h5000;
        done_cnt = 0;
        prn_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            sif.step = 1'b1;
            tick;
            sif.step = 1'b0;
            done_cnt += int'(sif.instr_done);
            prn_cnt  += int'(sif.print_en);
            for (int c = 0; c < 7; c++) begin
                tick;
                done_cnt += int'(sif.instr_done);
                prn_cnt  += int'(sif.print_en);
            end
        end
`ifdef SINGLE_STEP_EN
        chk("step_done", 32'(done_cnt), 3);
        chk("step_pc", 32'(sif.pc), 3);
        chk("step_print", 32'(prn_cnt), 1);
`else
        chk("step_done", 32'(done_cnt), 0);
        chk("step_pc", 32'(sif.pc), 0);
        chk("step_print", 32'(prn_cnt), 0);
`endif
        chk("step_busy", 32'(sif.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
